perpendicularize_pipe: RTL and testbench

// Parametrised successor to the single-mode perpendicularize unit. Given a line slope m (signed fixed point) and a

---
 rtl/perpendicularize_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_perpendicularize_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perpendicularize_pipe.sv
// perpendicularize_pipe: builds the line through (x_com, y_com) that is perpendicular
// (m' = -1/m) or parallel (m' = m) to the given slope. Uses a one-bit-per-cycle
// restoring divider and valid/ready handshakes on both sides, and passes a tag through.
module perpendicularize_pipe #(
   parameter int M_W  = 25,
   parameter int FRAC = 8,
   parameter int B_W  = 18,
   parameter int X_W  = 11,
   parameter int Y_W  = 10,
   parameter int ID_W = 2
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic [M_W-1:0]  m_in,
   input  logic [X_W-1:0]  x_com,
   input  logic [Y_W-1:0]  y_com,
   input  logic            mode_in,
   input  logic [ID_W-1:0] id_in,
   input  logic            valid_in,
   output logic            ready_out,
   output logic [M_W-1:0]  m_out,
   output logic [B_W-1:0]  b_out,
   output logic            vertical_out,
   output logic            sat_out,
   output logic [ID_W-1:0] id_out,
   output logic            valid_out,
   input  logic            ready_in
);

   // Quotient of 2^(2*FRAC) / |m| needs 2*FRAC+1 bits. The top bit is resolved on the
   // accept edge, so the DIV state itself runs 2*FRAC steps.
   localparam int QW        = 2*FRAC + 1;
   localparam int DIV_STEPS = 2*FRAC;
   localparam int CW        = $clog2(DIV_STEPS + 1);
   localparam int SW        = ((QW > M_W) ? QW : M_W) + 2;
   localparam int PW        = M_W + X_W + 1;
   localparam int BW        = M_W + X_W + 2;
   localparam logic [CW-1:0] LAST_STEP = CW'(DIV_STEPS - 1);
   localparam logic signed [SW-1:0] SLOPE_MAX = {{(SW-M_W+1){1'b0}}, {(M_W-1){1'b1}}};
   localparam logic signed [SW-1:0] SLOPE_MIN = {{(SW-M_W+1){1'b1}}, {(M_W-1){1'b0}}};
   localparam logic signed [BW-1:0] B_MAX = {{(BW-B_W+1){1'b0}}, {(B_W-1){1'b1}}};
   localparam logic signed [BW-1:0] B_MIN = {{(BW-B_W+1){1'b1}}, {(B_W-1){1'b0}}};
   localparam logic [M_W-1:0] ONE_M = {{(M_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

   state_t                state_q, state_d;
   logic [M_W-1:0]        div_q, rem_q;
   logic [QW-1:0]         quo_q;
   logic [CW-1:0]         cnt_q;
   logic                  neg_q;
   logic signed [M_W-1:0] slope_q;
   logic                  slopeClip_q;
   logic [X_W-1:0]        x_q;
   logic [Y_W-1:0]        y_q;
   logic [ID_W-1:0]       id_q;
   logic [M_W-1:0]        mOut_q;
   logic [B_W-1:0]        bOut_q;
   logic                  vert_q, sat_q;
   logic [ID_W-1:0]       idOut_q;

   logic                  accept, mInZero, unitDivisor;
   logic [M_W-1:0]        absIn;
   logic [M_W:0]          remShift;
   logic                  takeBit;
   logic [M_W-1:0]        remNext;
   logic [QW-1:0]         quoNext;
   logic signed [SW-1:0]  qWide, slopeWide;
   logic                  slopeHi, slopeLo;
   logic [M_W-1:0]        slopeSat;
   logic signed [PW-1:0]  prod, pShift;
   logic signed [BW-1:0]  bWide;
   logic                  bHi, bLo;
   logic [B_W-1:0]        bSat;

   assign accept      = valid_in & ready_out;
   assign mInZero     = (m_in == '0);
   assign absIn       = m_in[M_W-1] ? (-m_in) : m_in;
   assign unitDivisor = (absIn == ONE_M);

   // One restoring-division step: the dividend below its top bit is all zeros,
   // so each step just doubles the partial remainder.
   always_comb begin
      remShift = {rem_q, 1'b0};
      takeBit  = (remShift >= {1'b0, div_q});
      remNext  = takeBit ? (remShift[M_W-1:0] - div_q) : remShift[M_W-1:0];
      quoNext  = {quo_q[QW-2:0], takeBit};
   end

   // Perpendicular slope is -sign(m)*q, clipped to the signed slope range.
   always_comb begin
      qWide     = {{(SW-QW){1'b0}}, quoNext};
      slopeWide = neg_q ? qWide : -qWide;
      slopeHi   = (slopeWide > SLOPE_MAX);
      slopeLo   = (slopeWide < SLOPE_MIN);
      slopeSat  = slopeHi ? SLOPE_MAX[M_W-1:0] :
                  slopeLo ? SLOPE_MIN[M_W-1:0] : slopeWide[M_W-1:0];
   end

   // Intercept b = y - floor(m'*x / 2^FRAC), evaluated wide and then clipped.
   always_comb begin
      prod   = PW'(slope_q) * PW'($signed({1'b0, x_q}));
      pShift = prod >>> FRAC;
      bWide  = BW'($signed({1'b0, y_q})) - BW'(pShift);
      bHi    = (bWide > B_MAX);
      bLo    = (bWide < B_MIN);
      bSat   = bHi ? B_MAX[B_W-1:0] : bLo ? B_MIN[B_W-1:0] : bWide[B_W-1:0];
   end

   // State register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state selection: the request type picks the path out of IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = mode_in ? MUL : (mInZero ? DONE : DIV);
         DIV:  if (cnt_q == LAST_STEP) state_d = MUL;
         MUL:  state_d = DONE;
         DONE: if (ready_in) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs; ready is held low while reset is asserted.
   always_comb begin
      ready_out = (state_q == IDLE) & rst_n_in;
      valid_out = (state_q == DONE);
   end

   // Operand capture, divider iteration and result registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         div_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         neg_q       <= 1'b0;
         slope_q     <= '0;
         slopeClip_q <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         id_q        <= '0;
         mOut_q      <= '0;
         bOut_q      <= '0;
         vert_q      <= 1'b0;
         sat_q       <= 1'b0;
         idOut_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  x_q         <= x_com;
                  y_q         <= y_com;
                  id_q        <= id_in;
                  slope_q     <= m_in;
                  slopeClip_q <= 1'b0;
                  neg_q       <= m_in[M_W-1];
                  div_q       <= absIn;
                  rem_q       <= unitDivisor ? '0 : ONE_M;
                  quo_q       <= {{(QW-1){1'b0}}, unitDivisor};
                  cnt_q       <= '0;
                  if (!mode_in && mInZero) begin
                     mOut_q  <= SLOPE_MAX[M_W-1:0];
                     bOut_q  <= B_W'(x_com);
                     vert_q  <= 1'b1;
                     sat_q   <= 1'b0;
                     idOut_q <= id_in;
                  end
               end
            end
            DIV: begin
               rem_q <= remNext;
               quo_q <= quoNext;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_STEP) begin
                  slope_q     <= slopeSat;
                  slopeClip_q <= slopeHi | slopeLo;
               end
            end
            MUL: begin
               mOut_q  <= slope_q;
               bOut_q  <= bSat;
               vert_q  <= 1'b0;
               sat_q   <= slopeClip_q | bHi | bLo;
               idOut_q <= id_q;
            end
            default: ;
         endcase
      end
   end

   assign m_out        = mOut_q;
   assign b_out        = bOut_q;
   assign vertical_out = vert_q;
   assign sat_out      = sat_q;
   assign id_out       = idOut_q;

endmodule

// File: tb/tb_perpendicularize_pipe.sv
// Testbench for perpendicularize_pipe: directed vectors, randomized jobs against an
// arithmetic reference model, backpressure, back-to-back and mid-divide reset.
module tb_perpendicularize_pipe;

   localparam int M_W  = 25;
   localparam int FRAC = 8;
   localparam int B_W  = 18;
   localparam int X_W  = 11;
   localparam int Y_W  = 10;
   localparam int ID_W = 2;

   logic            clk_in = 1'b0;
   logic            rst_n_in = 1'b0;
   logic [M_W-1:0]  m_in = '0;
   logic [X_W-1:0]  x_com = '0;
   logic [Y_W-1:0]  y_com = '0;
   logic            mode_in = 1'b0;
   logic [ID_W-1:0] id_in = '0;
   logic            valid_in = 1'b0;
   logic            ready_out;
   logic [M_W-1:0]  m_out;
   logic [B_W-1:0]  b_out;
   logic            vertical_out;
   logic            sat_out;
   logic [ID_W-1:0] id_out;
   logic            valid_out;
   logic            ready_in = 1'b0;

   int checks = 0;
   int errors = 0;

   longint gotM, gotB;
   bit     gotV, gotS;
   int     gotId, gotLat;

   perpendicularize_pipe #(
      .M_W(M_W), .FRAC(FRAC), .B_W(B_W), .X_W(X_W), .Y_W(Y_W), .ID_W(ID_W)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .m_in(m_in), .x_com(x_com), .y_com(y_com),
      .mode_in(mode_in), .id_in(id_in), .valid_in(valid_in), .ready_out(ready_out),
      .m_out(m_out), .b_out(b_out), .vertical_out(vertical_out), .sat_out(sat_out),
      .id_out(id_out), .valid_out(valid_out), .ready_in(ready_in)
   );

   always #5 clk_in = ~clk_in;

   // Reference model straight from the arithmetic definition of the result line.
   task automatic model(input longint m, input longint x, input longint y, input bit par,
                        output longint em, output longint eb, output bit ev,
                        output bit es, output int elat);
      longint maxM, minM, maxB, minB, slope, q, p, fl, b;
      maxM = (longint'(1) << (M_W-1)) - 1;
      minM = -(longint'(1) << (M_W-1));
      maxB = (longint'(1) << (B_W-1)) - 1;
      minB = -(longint'(1) << (B_W-1));
      ev = 0; es = 0;
      if (!par && m == 0) begin
         em = maxM; eb = x; ev = 1; elat = 1;
         return;
      end
      if (par) begin
         slope = m; elat = 2;
      end else begin
         q = (longint'(1) << (2*FRAC)) / ((m < 0) ? -m : m);
         slope = (m < 0) ? q : -q;
         if (slope > maxM) begin slope = maxM; es = 1; end
         if (slope < minM) begin slope = minM; es = 1; end
         elat = 2*FRAC + 2;
      end
      p  = slope * x;
      fl = p / (longint'(1) << FRAC);
      if (p < 0 && (p % (longint'(1) << FRAC)) != 0) fl = fl - 1;
      b  = y - fl;
      if (b > maxB) begin b = maxB; es = 1; end
      if (b < minB) begin b = minB; es = 1; end
      em = slope; eb = b;
   endtask

   // Present one request, wait for the result and capture it (no handshake yet).
   task automatic run_job(input logic [M_W-1:0] m, input logic [X_W-1:0] x,
                          input logic [Y_W-1:0] y, input logic mode,
                          input logic [ID_W-1:0] id, input logic early);
      int waitCnt;
      m_in = m; x_com = x; y_com = y; mode_in = mode; id_in = id;
      valid_in = 1'b1; ready_in = early;
      waitCnt = 0;
      while (!ready_out && waitCnt < 50) begin
         @(posedge clk_in); #1; waitCnt++;
      end
      @(posedge clk_in); #1;
      valid_in = 1'b0;
      m_in = M_W'($urandom); x_com = X_W'($urandom); y_com = Y_W'($urandom);
      mode_in = 1'($urandom); id_in = ID_W'($urandom);
      gotLat = 1;
      while (!valid_out && gotLat < 100) begin
         @(posedge clk_in); #1; gotLat++;
      end
      gotM = longint'($signed(m_out)); gotB = longint'($signed(b_out));
      gotV = vertical_out; gotS = sat_out; gotId = int'(id_out);
   endtask

   task automatic handshake();
      ready_in = 1'b1;
      @(posedge clk_in); #1;
      ready_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0;
      #12;
      checks++;
      if ({valid_out, m_out, b_out, vertical_out, sat_out, id_out} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got v=%0b m=%0d b=%0d vert=%0b sat=%0b id=%0d expected all 0",
                  valid_out, m_out, b_out, vertical_out, sat_out, id_out);
      end
      @(negedge clk_in); rst_n_in = 1'b1;
      @(posedge clk_in); #1;
      checks++;
      if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_release: got ready=%0b valid=%0b expected ready=1 valid=0",
                  ready_out, valid_out);
      end
   endtask

   typedef struct {
      longint m; longint x; longint y; bit par; int id;
      longint em; longint eb; bit ev; bit es; int lat;
   } vec_t;

   task automatic test_directed();
      vec_t vecs[10];
      vecs[0] = '{256,      100,  500, 0, 0, -256,     600,     0, 0, 18};
      vecs[1] = '{768,      100,  500, 0, 1, -85,      534,     0, 0, 18};
      vecs[2] = '{256,      100,  500, 1, 2, 256,      400,     0, 0, 2};
      vecs[3] = '{0,        37,   9,   0, 3, 16777215, 37,      1, 0, 1};
      vecs[4] = '{25600,    2047, 0,   1, 0, 25600,    -131072, 0, 1, 2};
      vecs[5] = '{-512,     100,  500, 0, 1, 128,      450,     0, 0, 18};
      vecs[6] = '{1,        2047, 0,   0, 2, -65536,   131071,  0, 1, 18};
      vecs[7] = '{-16777216, 5,   7,   0, 3, 0,        7,       0, 0, 18};
      vecs[8] = '{-256,     3,    0,   1, 0, -256,     3,       0, 0, 2};
      vecs[9] = '{-1,       1,    10,  1, 1, -1,       11,      0, 0, 2};
      for (int i = 0; i < 10; i++) begin
         run_job(M_W'(vecs[i].m), X_W'(vecs[i].x), Y_W'(vecs[i].y), vecs[i].par,
                 ID_W'(vecs[i].id), 1'b0);
         checks++;
         if (gotM !== vecs[i].em) begin
            errors++; $display("[TB] FAIL directed%0d_m: got %0d expected %0d", i, gotM, vecs[i].em);
         end
         checks++;
         if (gotB !== vecs[i].eb) begin
            errors++; $display("[TB] FAIL directed%0d_b: got %0d expected %0d", i, gotB, vecs[i].eb);
         end
         checks++;
         if (gotV !== vecs[i].ev || gotS !== vecs[i].es) begin
            errors++; $display("[TB] FAIL directed%0d_flags: got vert=%0b sat=%0b expected vert=%0b sat=%0b",
                               i, gotV, gotS, vecs[i].ev, vecs[i].es);
         end
         checks++;
         if (gotId !== vecs[i].id) begin
            errors++; $display("[TB] FAIL directed%0d_id: got %0d expected %0d", i, gotId, vecs[i].id);
         end
         checks++;
         if (gotLat !== vecs[i].lat) begin
            errors++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, gotLat, vecs[i].lat);
         end
         handshake();
      end
   endtask

   task automatic test_random();
      logic [M_W-1:0] m;
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic par;
      logic [ID_W-1:0] id;
      longint em, eb;
      bit ev, es;
      int elat;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: m = '0;
            1: m = M_W'($urandom_range(1, 1024));
            2: m = M_W'($urandom);
            default: m = M_W'($urandom_range(1, 65536));
         endcase
         if ($urandom_range(0, 1) == 1) m = -m;
         x = X_W'($urandom); y = Y_W'($urandom);
         par = 1'($urandom); id = ID_W'($urandom);
         model(longint'($signed(m)), longint'(x), longint'(y), par, em, eb, ev, es, elat);
         run_job(m, x, y, par, id, 1'($urandom));
         checks++;
         if (gotM !== em || gotB !== eb) begin
            errors++; $display("[TB] FAIL random%0d_mb: got m=%0d b=%0d expected m=%0d b=%0d",
                               i, gotM, gotB, em, eb);
         end
         checks++;
         if (gotV !== ev || gotS !== es || gotId !== int'(id)) begin
            errors++; $display("[TB] FAIL random%0d_flags: got vert=%0b sat=%0b id=%0d expected vert=%0b sat=%0b id=%0d",
                               i, gotV, gotS, gotId, ev, es, id);
         end
         checks++;
         if (gotLat !== elat) begin
            errors++; $display("[TB] FAIL random%0d_latency: got %0d expected %0d", i, gotLat, elat);
         end
         handshake();
      end
   endtask

   task automatic test_backpressure();
      int lateValid;
      run_job(M_W'(768), X_W'(100), Y_W'(500), 1'b0, ID_W'(1), 1'b0);
      for (int c = 0; c < 10; c++) begin
         m_in = M_W'(256); x_com = X_W'(1); y_com = Y_W'(2); mode_in = 1'b1; id_in = ID_W'(3);
         valid_in = 1'b1; ready_in = 1'b0;
         @(posedge clk_in); #1;
         checks++;
         if (longint'($signed(m_out)) !== longint'(-85) || longint'($signed(b_out)) !== longint'(534) ||
             id_out !== ID_W'(1) || valid_out !== 1'b1 || ready_out !== 1'b0) begin
            errors++; $display("[TB] FAIL backpressure_hold%0d: got m=%0d b=%0d id=%0d valid=%0b ready=%0b expected m=-85 b=534 id=1 valid=1 ready=0",
                               c, $signed(m_out), $signed(b_out), id_out, valid_out, ready_out);
         end
      end
      valid_in = 1'b0;
      handshake();
      checks++;
      if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
         errors++; $display("[TB] FAIL backpressure_release: got valid=%0b ready=%0b expected valid=0 ready=1",
                            valid_out, ready_out);
      end
      lateValid = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk_in); #1;
         if (valid_out) lateValid++;
      end
      checks++;
      if (lateValid !== 0) begin
         errors++; $display("[TB] FAIL backpressure_ignored: got %0d valid cycles expected 0", lateValid);
      end
   endtask

   task automatic test_back_to_back();
      run_job(M_W'(512), X_W'(10), Y_W'(100), 1'b1, ID_W'(2), 1'b1);
      checks++;
      if (gotB !== 80 || gotLat !== 2) begin
         errors++; $display("[TB] FAIL b2b_first: got b=%0d lat=%0d expected b=80 lat=2", gotB, gotLat);
      end
      handshake();
      checks++;
      if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
         errors++; $display("[TB] FAIL b2b_gap: got ready=%0b valid=%0b expected ready=1 valid=0",
                            ready_out, valid_out);
      end
      run_job(M_W'(0), X_W'(1000), Y_W'(3), 1'b0, ID_W'(1), 1'b0);
      checks++;
      if (gotV !== 1'b1 || gotB !== 1000 || gotId !== 1 || gotLat !== 1) begin
         errors++; $display("[TB] FAIL b2b_second: got vert=%0b b=%0d id=%0d lat=%0d expected vert=1 b=1000 id=1 lat=1",
                            gotV, gotB, gotId, gotLat);
      end
      handshake();
   endtask

   task automatic test_reset_mid();
      int staleValid;
      m_in = M_W'(768); x_com = X_W'(100); y_com = Y_W'(500); mode_in = 1'b0; id_in = ID_W'(3);
      valid_in = 1'b1;
      @(posedge clk_in); #1;
      valid_in = 1'b0;
      repeat (5) @(posedge clk_in);
      #2 rst_n_in = 1'b0;
      #1;
      checks++;
      if ({valid_out, ready_out, m_out, b_out, vertical_out, sat_out, id_out} !== '0) begin
         errors++; $display("[TB] FAIL midreset_outputs: got v=%0b r=%0b m=%0d b=%0d vert=%0b sat=%0b id=%0d expected all 0",
                            valid_out, ready_out, m_out, b_out, vertical_out, sat_out, id_out);
      end
      @(negedge clk_in); rst_n_in = 1'b1;
      @(posedge clk_in); #1;
      checks++;
      if (ready_out !== 1'b1) begin
         errors++; $display("[TB] FAIL midreset_ready: got %0b expected 1", ready_out);
      end
      staleValid = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk_in); #1;
         if (valid_out) staleValid++;
      end
      checks++;
      if (staleValid !== 0) begin
         errors++; $display("[TB] FAIL midreset_stale: got %0d valid cycles expected 0", staleValid);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit so a stuck handshake can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
